// File: rtl/mm2s_pkt_fifo.sv
// Single-clock packet FIFO with keep/last sideband, level and packet counters, flush.
// Define MM2S_PKT_FIFO_SAF_EN to hold the head until a whole packet is stored.
module mm2s_pkt_fifo #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [DATA_W-1:0]            push_data,
  input  logic [DATA_W/8-1:0]          push_keep,
  input  logic                         push_last,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [DATA_W-1:0]            pop_data,
  output logic [DATA_W/8-1:0]          pop_keep,
  output logic                         pop_last,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned KW = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KW-1:0]     keep;
    logic              last;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          rel_ok;
  logic          do_push;
  logic          do_pop;
  logic          pkt_inc;
  logic          pkt_dec;

  // Status decode; depends only on registered level.
  always_comb begin
    full         = (level == LW'(DEPTH));
    empty        = (level == '0);
    almost_full  = (level >= LW'(AF_THRESH));
    almost_empty = (level <= LW'(AE_THRESH));
  end

`ifdef MM2S_PKT_FIFO_SAF_EN
  // The full term drains oversize packets rather than deadlocking.
  assign rel_ok = (pkt_count != '0) | full;
`else
  assign rel_ok = 1'b1;
`endif

  always_comb begin
    push_ready = !full && !flush;
    pop_valid  = !empty && !flush && rel_ok;
    do_push    = push_valid && push_ready;
    do_pop     = pop_valid && pop_ready;
    head       = mem[rd_ptr];
    pop_data   = head.data;
    pop_keep   = head.keep;
    pop_last   = head.last;
    pkt_inc    = do_push && push_last;
    pkt_dec    = do_pop && head.last;
  end

  // Storage is not reset; contents are only meaningful below level.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{data: push_data, keep: push_keep, last: push_last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_count <= pkt_count + LW'(1);
        2'b01:   pkt_count <= pkt_count - LW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule
